// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: per-channel off / PWM / blink / breathe,
// configured through shadow registers loaded on a single-cycle strobe.
module led_pattern_gen #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned TICK_DIV = 27000,
  parameter int unsigned BLINK_W  = 16
) (
  input  logic                       clk27m,
  input  logic                       rst_n,
  input  logic                       cfg_load,
  input  logic [2*N_CH-1:0]          mode_in,
  input  logic [PWM_BITS*N_CH-1:0]   duty_in,
  input  logic [BLINK_W-1:0]         blink_half_in,
  output logic [N_CH-1:0]            led_out,
  output logic                       tick_out
);

  localparam int unsigned PresW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(TICK_DIV - 1);
  localparam logic [PWM_BITS-1:0] LevelMax = '1;

  typedef enum logic [1:0] {
    ModeOff     = 2'b00,
    ModePwm     = 2'b01,
    ModeBlink   = 2'b10,
    ModeBreathe = 2'b11
  } mode_e;

  logic [PresW-1:0]           presc_q, presc_d;
  logic                       tick;
  logic                       tick_q, tick_d;
  logic [PWM_BITS-1:0]        pwm_cnt_q, pwm_cnt_d;

  logic [2*N_CH-1:0]          mode_q, mode_d;
  logic [PWM_BITS*N_CH-1:0]   duty_q, duty_d;
  logic [BLINK_W-1:0]         half_q, half_d;

  logic [BLINK_W-1:0]         blink_cnt_q, blink_cnt_d;
  logic                       blink_phase_q, blink_phase_d;
  logic [BLINK_W-1:0]         half_eff;
  logic [BLINK_W:0]           blink_cnt_inc;

  logic [PWM_BITS-1:0]        level_q, level_d;
  logic                       dir_q, dir_d;  // 0 = ramping up, 1 = ramping down

  logic [N_CH-1:0]            led_q, led_d;

  always_ff @(posedge clk27m or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      tick_q        <= 1'b0;
      pwm_cnt_q     <= '0;
      mode_q        <= '0;
      duty_q        <= '0;
      half_q        <= BLINK_W'(1);
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      level_q       <= '0;
      dir_q         <= 1'b0;
      led_q         <= '0;
    end else begin
      presc_q       <= presc_d;
      tick_q        <= tick_d;
      pwm_cnt_q     <= pwm_cnt_d;
      mode_q        <= mode_d;
      duty_q        <= duty_d;
      half_q        <= half_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      level_q       <= level_d;
      dir_q         <= dir_d;
      led_q         <= led_d;
    end
  end

  // Prescaler, PWM counter, shadow capture and the shared pattern engines.
  always_comb begin
    tick          = (presc_q == PresMax);
    presc_d       = tick ? '0 : presc_q + PresW'(1);
    tick_d        = tick;
    pwm_cnt_d     = pwm_cnt_q + PWM_BITS'(1);

    half_eff      = (half_q == '0) ? BLINK_W'(1) : half_q;
    blink_cnt_inc = {1'b0, blink_cnt_q} + (BLINK_W + 1)'(1);

    mode_d        = mode_q;
    duty_d        = duty_q;
    half_d        = half_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    level_d       = level_q;
    dir_d         = dir_q;

    // A load restarts the engines and swallows a coincident tick so every
    // channel begins its pattern from the same phase.
    if (cfg_load) begin
      mode_d        = mode_in;
      duty_d        = duty_in;
      half_d        = blink_half_in;
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
      level_d       = '0;
      dir_d         = 1'b0;
    end else if (tick) begin
      if (blink_cnt_inc >= {1'b0, half_eff}) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d   = blink_cnt_inc[BLINK_W-1:0];
      end

      if (!dir_q) begin
        // Reaching the top flips direction while holding the peak for one tick.
        if (level_q == LevelMax) begin
          dir_d = 1'b1;
        end else begin
          level_d = level_q + PWM_BITS'(1);
        end
      end else begin
        level_d = level_q - PWM_BITS'(1);
        if (level_q == PWM_BITS'(1)) begin
          dir_d = 1'b0;
        end
      end
    end
  end

  always_comb begin
    led_d = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (mode_e'(mode_q[2*i +: 2]))
        ModeOff:     led_d[i] = 1'b0;
        ModePwm:     led_d[i] = (pwm_cnt_q < duty_q[PWM_BITS*i +: PWM_BITS]);
        ModeBlink:   led_d[i] = blink_phase_q;
        ModeBreathe: led_d[i] = (pwm_cnt_q < level_q);
        default:     led_d[i] = 1'b0;
      endcase
    end
  end

  assign led_out  = led_q;
  assign tick_out = tick_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: stimulus queues per-cycle expectations
// derived from closed-form pattern formulas; a negedge monitor pops and compares.
module tb_led_pattern_gen;

  localparam int N_CH     = 4;
  localparam int PWM_BITS = 4;
  localparam int TICK_DIV = 4;
  localparam int BLINK_W  = 16;

  logic                     clk27m = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     cfg_load = 1'b0;
  logic [2*N_CH-1:0]        mode_in = '0;
  logic [PWM_BITS*N_CH-1:0] duty_in = '0;
  logic [BLINK_W-1:0]       blink_half_in = '0;
  logic [N_CH-1:0]          led_out;
  logic                     tick_out;

  led_pattern_gen #(
    .N_CH     (N_CH),
    .PWM_BITS (PWM_BITS),
    .TICK_DIV (TICK_DIV),
    .BLINK_W  (BLINK_W)
  ) dut (
    .clk27m        (clk27m),
    .rst_n         (rst_n),
    .cfg_load      (cfg_load),
    .mode_in       (mode_in),
    .duty_in       (duty_in),
    .blink_half_in (blink_half_in),
    .led_out       (led_out),
    .tick_out      (tick_out)
  );

  initial forever #5 clk27m = ~clk27m;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
    logic [3:0] led;
    bit         chk_tick;
    logic       tick;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc;

  // cyc = number of rising edges since the last reset release.
  always @(posedge clk27m or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic void check(string name, int c, logic [3:0] act, logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b expected=%b", name, c, act, exp);
    end
  endfunction

  function automatic void push(string name, int c, logic [3:0] mask, logic [3:0] led,
                               bit chk_tick = 1'b0, logic tick = 1'b0);
    exp_t e;
    e.cyc = c; e.mask = mask; e.led = led; e.chk_tick = chk_tick; e.tick = tick; e.name = name;
    sb.push_back(e);
  endfunction

  // Breathe level after j ticks from a restart: 0,1..15,15,14..0,1,...
  function automatic int lvl(int j);
    int m;
    m = j % 31;
    return (m <= 15) ? m : 31 - m;
  endfunction

  // led at edge k reflects pwm_cnt after edge k-1, which equals (k-1) mod 16.
  function automatic logic pwm_bit(int k, int level);
    return (((k - 1) % 16) < level);
  endfunction

  // Load edge L lands on a tick boundary; phase flips every 4*half clocks.
  function automatic logic blink_bit(int k, int l, int half);
    return ((((k - 1 - l) / (4 * half)) % 2) == 1);
  endfunction

  always @(negedge clk27m) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
        mon_e = sb.pop_front();
        if (mon_e.cyc < cyc) begin
          checks++;
          failures++;
          $display("FAIL %s missed cyc=%0d now=%0d", mon_e.name, mon_e.cyc, cyc);
        end else begin
          check(mon_e.name, cyc, led_out & mon_e.mask, mon_e.led & mon_e.mask);
          if (mon_e.chk_tick) check({mon_e.name, "_tick"}, cyc, {3'b0, tick_out},
                                    {3'b0, mon_e.tick});
        end
      end
    end
  end

  task automatic finish_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic wait_until(int target);
    int n;
    n = 0;
    while (cyc < target) begin
      @(negedge clk27m);
      n++;
      if (n > 5000) begin
        checks++;
        failures++;
        $display("FAIL wait_timeout cyc=%0d target=%0d", cyc, target);
        finish_run();
      end
    end
    check("scoreboard_drained", cyc, 4'(sb.size()), 4'd0);
  endtask

  // Holds cfg_load for `hold` cycles so the last capture edge L is a multiple of 16.
  task automatic load_cfg(input logic [7:0] mode, input logic [15:0] duty,
                          input logic [15:0] half, input int hold, output int l);
    @(negedge clk27m);
    while (((cyc + hold) % 16) != 0) @(negedge clk27m);
    mode_in       = mode;
    duty_in       = duty;
    blink_half_in = half;
    cfg_load      = 1'b1;
    repeat (hold) @(negedge clk27m);
    cfg_load      = 1'b0;
    l             = cyc;
  endtask

  initial begin
    int l;
    int l2;
    int duties[3];
    duties = '{4, 0, 15};

    #50;
    check("reset_led", 0, led_out, 4'b0000);
    check("reset_tick", 0, {3'b0, tick_out}, 4'b0000);
    #52 rst_n = 1'b1;

    for (int k = 1; k <= 12; k++) push("post_reset", k, 4'hF, 4'h0, 1'b1, (k % 4) == 0);
    wait_until(13);

    foreach (duties[i]) begin
      load_cfg(8'b00_00_00_01, 16'(duties[i]), 16'd1, 1, l);
      for (int k = l + 2; k <= l + 33; k++)
        push($sformatf("pwm_d%0d", duties[i]), k, 4'b0001, {3'b0, pwm_bit(k, duties[i])});
      wait_until(l + 34);
    end

    load_cfg(8'b00_00_10_00, 16'h0000, 16'd3, 1, l);
    for (int k = l + 2; k <= l + 50; k++)
      push("blink_h3", k, 4'b0010, {2'b0, blink_bit(k, l, 3), 1'b0});
    wait_until(l + 51);

    load_cfg(8'b00_00_10_00, 16'h0000, 16'd0, 3, l);
    for (int k = l + 2; k <= l + 30; k++)
      push("blink_h0_hold", k, 4'b0010, {2'b0, blink_bit(k, l, 1), 1'b0});
    wait_until(l + 31);

    load_cfg(8'b00_11_00_00, 16'h0000, 16'd1, 1, l);
    for (int k = l + 2; k <= l + 134; k++)
      push("breathe", k, 4'b0100, {1'b0, pwm_bit(k, lvl((k - 1 - l) / 4)), 2'b0});
    wait_until(l + 135);

    load_cfg(8'b11_10_01_00, 16'hFF8F, 16'd3, 1, l);
    wait_until(l + 22);
    load_cfg(8'b11_10_01_00, 16'hFF8F, 16'd3, 1, l2);
    for (int k = l2 + 2; k <= l2 + 70; k++)
      push("mixed_reload", k, 4'hF,
           {pwm_bit(k, lvl((k - 1 - l2) / 4)), blink_bit(k, l2, 3), pwm_bit(k, 8), 1'b0});
    wait_until(l2 + 71);

    load_cfg(8'b00_11_00_00, 16'h0000, 16'd1, 1, l);
    for (int k = l + 2; k <= l + 38; k++)
      push("breathe_pre_rst", k, 4'b0100, {1'b0, pwm_bit(k, lvl((k - 1 - l) / 4)), 2'b0});
    wait_until(l + 39);
    check("level9_high", cyc, {1'b0, led_out[2], 2'b0}, 4'b0100);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led", cyc, led_out, 4'b0000);
    check("async_rst_tick", cyc, {3'b0, tick_out}, 4'b0000);
    #100 rst_n = 1'b1;

    for (int k = 1; k <= 8; k++) push("post_rst2", k, 4'hF, 4'h0, 1'b1, (k % 4) == 0);
    wait_until(9);
    load_cfg(8'b00_11_00_00, 16'h0000, 16'd1, 1, l);
    for (int k = l + 2; k <= l + 70; k++)
      push("breathe_after_rst", k, 4'b0100, {1'b0, pwm_bit(k, lvl((k - 1 - l) / 4)), 2'b0});
    wait_until(l + 71);

    finish_run();
  end

endmodule
